// File: rtl/regfile_wb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_wb_pkg                                                    |
// | Shared widths and the write-back request type.                    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package regfile_wb_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int DEFAULT_XLEN = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [DEFAULT_XLEN-1:0] data;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_wb_if                                                     |
// | ALU/LSU result inputs and register-file write port.               |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface regfile_wb_if
  import regfile_wb_pkg::*;
#(
  parameter int XLEN      = DEFAULT_XLEN,
  parameter int LSU_DEPTH = 2
) ();

  logic                         alu_valid;
  logic                         alu_ready;
  logic [REG_ADDR_W-1:0]        alu_rd;
  logic [XLEN-1:0]              alu_data;
  logic                         lsu_valid;
  logic                         lsu_ready;
  logic [REG_ADDR_W-1:0]        lsu_rd;
  logic [XLEN-1:0]              lsu_data;
  logic                         wenable;
  logic [REG_ADDR_W-1:0]        rd;
  logic [XLEN-1:0]              wdata;
  logic [$clog2(LSU_DEPTH+1)-1:0] lsu_count;

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, wenable, rd, wdata, lsu_count
  );

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, wenable, rd, wdata, lsu_count
  );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_fifo                                                           |
// | Synchronous FIFO of write-back requests, extra-bit pointers.      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     push,
  input  wire wb_req_t                  push_data,
  input  wire logic                     pop,
  output wb_req_t                       head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int c_AW = $clog2(DEPTH);

  wb_req_t         r_mem [DEPTH];
  logic [c_AW:0]   r_wr_ptr;
  logic [c_AW:0]   r_rd_ptr;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                 (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign count = r_wr_ptr - r_rd_ptr;
  assign head  = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push && !full) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop && !empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_wb                                                        |
// | Merges ALU and buffered LSU results onto the register-file port.  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int XLEN         = DEFAULT_XLEN,
  parameter int LSU_DEPTH    = 2,
  parameter int STARVE_LIMIT = 3
) (
  input wire logic     clk,
  input wire logic     rst_n,
  regfile_wb_if.slave  bus
);

  localparam int               c_SW    = $clog2(STARVE_LIMIT+1);
  localparam logic [c_SW-1:0]  c_LIMIT = c_SW'(STARVE_LIMIT);

  wb_req_t                 w_push_req;
  wb_req_t                 w_head;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_force;
  logic                    w_sel_alu;
  logic [c_SW-1:0]         r_starve;
  logic                    r_wenable;
  logic [REG_ADDR_W-1:0]   r_rd;
  logic [XLEN-1:0]         r_wdata;

  assign w_push_req = '{rd: bus.lsu_rd, data: bus.lsu_data};
  assign w_push     = bus.lsu_valid && !w_full;

  wb_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_req),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (bus.lsu_count)
  );

  // The waiting LSU head takes the slot once the ALU has won STARVE_LIMIT times.
  assign w_force   = (r_starve == c_LIMIT) && !w_empty;
  assign w_sel_alu = !w_force && bus.alu_valid;
  assign w_pop     = w_force || (!bus.alu_valid && !w_empty);

  assign bus.alu_ready = !w_force;
  assign bus.lsu_ready = !w_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_pop || w_empty) begin
      r_starve <= '0;
    end else if (w_sel_alu && (r_starve != c_LIMIT)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wenable <= 1'b0;
      r_rd      <= '0;
      r_wdata   <= '0;
    end else if (w_pop) begin
      r_wenable <= (w_head.rd != '0);
      r_rd      <= w_head.rd;
      r_wdata   <= w_head.data;
    end else if (w_sel_alu) begin
      r_wenable <= (bus.alu_rd != '0);
      r_rd      <= bus.alu_rd;
      r_wdata   <= bus.alu_data;
    end else begin
      r_wenable <= 1'b0;
    end
  end

  assign bus.wenable = r_wenable;
  assign bus.rd      = r_rd;
  assign bus.wdata   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_regfile_wb                                                     |
// | Directed bench with a queue-level write-back reference model.     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_regfile_wb;

  localparam int XLEN         = 32;
  localparam int LSU_DEPTH    = 2;
  localparam int STARVE_LIMIT = 3;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_if #(.XLEN(XLEN), .LSU_DEPTH(LSU_DEPTH)) bus ();

  regfile_wb #(
    .XLEN(XLEN), .LSU_DEPTH(LSU_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of pending LSU results and a count of ALU wins
  // since the current head started waiting.
  ent_t        m_q[$];
  int          m_wins = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_wd = '0;
  bit          model_valid = 1'b0;
  bit          m_take;
  ent_t        m_e;

  always @(negedge clk) begin
    if (model_valid) begin
      check("alu_ready", bus.alu_ready, !(m_wins >= STARVE_LIMIT && m_q.size() > 0));
      check("lsu_ready", bus.lsu_ready, m_q.size() < LSU_DEPTH);
      check("wenable", bus.wenable, m_we);
      check("rd", bus.rd, m_rd);
      check("wdata", bus.wdata, m_wd);
      check("lsu_count", bus.lsu_count, m_q.size());
    end
    if (!rst_n) begin
      m_q.delete();
      m_wins = 0;
      m_we = 1'b0; m_rd = '0; m_wd = '0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      m_take = bus.lsu_valid && (m_q.size() < LSU_DEPTH);
      if (m_q.size() > 0 && (m_wins >= STARVE_LIMIT || !bus.alu_valid)) begin
        m_e = m_q.pop_front();
        m_we = (m_e.rd != 0); m_rd = m_e.rd; m_wd = m_e.data;
        m_wins = 0;
      end else if (bus.alu_valid) begin
        m_we = (bus.alu_rd != 0); m_rd = bus.alu_rd; m_wd = bus.alu_data;
        if (m_q.size() == 0) m_wins = 0;
        else if (m_wins < STARVE_LIMIT) m_wins = m_wins + 1;
      end else begin
        m_we = 1'b0;
        m_wins = 0;
      end
      if (m_take) m_q.push_back('{bus.lsu_rd, bus.lsu_data});
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
  endtask

  int         k, m, stalls, leaks;
  bit         acc_a, acc_l, saw_full;
  logic [4:0] wr_q[$];
  logic [4:0] lsu_wr[$];
  int         exp_starve[6] = '{1, 2, 3, 4, 9, 5};
  int         exp_lsu[3]    = '{10, 11, 12};

  initial begin
    idle();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    check("reset_wenable", bus.wenable, 1'b0);
    check("reset_rd", bus.rd, 5'd0);
    check("reset_wdata", bus.wdata, 32'd0);
    check("reset_count", bus.lsu_count, 2'd0);
    check("reset_alu_ready", bus.alu_ready, 1'b1);
    check("reset_lsu_ready", bus.lsu_ready, 1'b1);

    // ALU only, including an x0 write
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    cycle();
    check("alu_we", bus.wenable, 1'b1);
    check("alu_rd", bus.rd, 5'd5);
    check("alu_wdata", bus.wdata, 32'hDEADBEEF);
    bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
    cycle();
    check("alu_x0_we", bus.wenable, 1'b0);
    idle();
    cycle();

    // LSU only: write appears two cycles after accept
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'hA5A5A5A5;
    cycle();
    idle();
    check("lsu_count1", bus.lsu_count, 2'd1);
    check("lsu_we_early", bus.wenable, 1'b0);
    cycle();
    check("lsu_we", bus.wenable, 1'b1);
    check("lsu_rd", bus.rd, 5'd7);
    check("lsu_wdata", bus.wdata, 32'hA5A5A5A5);
    cycle();

    // Starvation under continuous ALU traffic
    k = 1; stalls = 0; wr_q.delete();
    for (int i = 0; i < 6; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(k); bus.alu_data = 32'(100 + k);
      bus.lsu_valid = (i == 0); bus.lsu_rd = 5'd9; bus.lsu_data = 32'h9999;
      acc_a = bus.alu_ready;
      if (!acc_a) stalls++;
      cycle();
      if (acc_a) k++;
      if (bus.wenable) wr_q.push_back(bus.rd);
    end
    idle();
    check("starve_stalls", stalls, 1);
    check("starve_writes", wr_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check("starve_order", (i < wr_q.size()) ? wr_q[i] : 5'h1f, exp_starve[i]);
    cycle();

    // FIFO full with saturating ALU
    k = 0; m = 10; saw_full = 1'b0; lsu_wr.delete();
    for (int i = 0; i < 16; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(20 + k % 10); bus.alu_data = 32'h1000 + 32'(k);
      bus.lsu_valid = (m <= 12); bus.lsu_rd = 5'(m); bus.lsu_data = 32'h5000 + 32'(m);
      acc_a = bus.alu_ready;
      acc_l = bus.lsu_ready && bus.lsu_valid;
      if (!bus.lsu_ready && bus.lsu_count == 2'd2) saw_full = 1'b1;
      cycle();
      if (acc_a) k++;
      if (acc_l) m++;
      if (bus.wenable && bus.rd >= 5'd10 && bus.rd <= 5'd12) lsu_wr.push_back(bus.rd);
    end
    idle();
    cycle();
    check("full_seen", saw_full, 1'b1);
    check("full_pushed", m, 13);
    check("full_writes", lsu_wr.size(), 3);
    for (int i = 0; i < 3; i++)
      check("full_order", (i < lsu_wr.size()) ? lsu_wr[i] : 5'h1f, exp_lsu[i]);
    cycle();

    // Reset mid-operation with two buffered entries
    for (int i = 0; i < 2; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h33;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(13 + i); bus.lsu_data = 32'h7000 + 32'(i);
      cycle();
    end
    idle();
    check("mid_count2", bus.lsu_count, 2'd2);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("mid_we", bus.wenable, 1'b0);
    check("mid_count0", bus.lsu_count, 2'd0);
    leaks = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (bus.wenable) leaks++;
    end
    check("mid_leaks", leaks, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb.md
# regfile_wb

Write-back arbiter that drives the single write port of the 32×32 register file. It merges results from the single-cycle ALU and the variable-latency load/store unit (LSU) into one registered write per cycle. LSU results are buffered in a small FIFO. A starvation counter guarantees LSU forward progress under continuous ALU traffic.

## Interface
- `XLEN`, default 32: data width.
- `LSU_DEPTH`, default 2: LSU FIFO entries; must be a power of two and ≥2.
- `STARVE_LIMIT`, default 3: consecutive ALU wins tolerated while an LSU entry waits; must be ≥1.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `alu_valid` input 1: ALU result present this cycle.
- `alu_ready` output 1: ALU result accepted this cycle; combinational.
- `alu_rd` input 5: ALU destination register.
- `alu_data` input XLEN: ALU result.
- `lsu_valid` input 1: LSU result offered.
- `lsu_ready` output 1: FIFO can accept; equals not-full.
- `lsu_rd` input 5: LSU destination register.
- `lsu_data` input XLEN: LSU result.
- `wenable` output 1: register-file write enable; registered.
- `rd` output 5: register-file write address; registered.
- `wdata` output XLEN: register-file write data; registered.
- `lsu_count` output $clog2(LSU_DEPTH+1): current FIFO occupancy.

## Operation
- LSU handshake:
  - Transfer occurs when `lsu_valid && lsu_ready`; the entry is pushed to the FIFO tail.
  - `lsu_ready` = !full. It is 0 when full, even if a pop occurs the same cycle; there is no full-pass-through.
  - The LSU path never bypasses the FIFO.
- Per-cycle selection, in priority order:
  1. Force-LSU: `starve_cnt == STARVE_LIMIT` and FIFO non-empty → select FIFO head and pop; `alu_ready` = 0.
  2. Else if `alu_valid` → select ALU; `alu_ready` = 1.
  3. Else if FIFO non-empty → select FIFO head and pop.
  4. Else no selection.
- `alu_ready` = !(`starve_cnt == STARVE_LIMIT` && !empty), independent of `alu_valid`.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, when the ALU is selected while the FIFO is non-empty.
  - Clears to 0 when an LSU entry is selected or when the FIFO is empty.
- Output register:
  - On a selection: `wenable` <= (sel_rd != 0), `rd` <= sel_rd, `wdata` <= sel_data.
  - With no selection: `wenable` <= 0; `rd`/`wdata` hold their previous values.
- x0 handling: a write to x0 still consumes its slot (ALU accepted or FIFO popped, counter updated as normal) but produces `wenable` = 0.
- Ordering:
  - LSU results retire in FIFO order.
  - No ordering is guaranteed between the ALU and LSU paths; the same-rd hazard is the issue stage's responsibility.
- Simultaneous push and pop on a non-empty, non-full FIFO: occupancy unchanged.
- Simultaneous push and pop on an empty FIFO: not possible, since pop requires non-empty at cycle start.

## Timing
- ALU latency: accept in cycle N → `wenable`/`rd`/`wdata` valid in cycle N+1.
- LSU minimum latency: accept in cycle N → earliest write in cycle N+2.
- Throughput: one register-file write per cycle maximum.
- Worst-case LSU wait with the FIFO head present: STARVE_LIMIT ALU writes, then a guaranteed LSU write.
- Reset values, applied at the first rising edge with `rst_n` = 0:
  - `wenable` 0, `rd` 0, `wdata` 0, `lsu_count` 0.
  - FIFO pointers 0, `starve_cnt` 0.
  - `lsu_ready` 1 and `alu_ready` 1 from the cycle after reset.
- Reset mid-operation: buffered LSU entries are discarded with no writes issued; the in-flight output write is cancelled (`wenable` 0 next cycle).

## Structure
- Package `regfile_wb_pkg`:
  - `REG_ADDR_W` = 5.
  - `XLEN` default.
  - typedef `wb_req_t` struct {rd[4:0], data[XLEN-1:0]}.
- Sub-module `wb_fifo`:
  - Parameterized synchronous FIFO of `wb_req_t`, with `LSU_DEPTH` entries.
  - Wrap-around pointers carry one extra bit for full/empty.
  - Exposes full, empty and count.
- Top level contains: selection logic, starvation counter, output register.

## Test plan
- Reset then idle: hold `rst_n` = 0 for 2 cycles, then release → `wenable` = 0, `rd` = 0, `wdata` = 0, `lsu_count` = 0, both readies 1.
- ALU only: ALU writes (rd = 5, 0xDEADBEEF), then (rd = 0, 0x1234) on consecutive cycles → `wenable` 1 with rd 5, 0xDEADBEEF next cycle; following cycle `wenable` 0.
- LSU only: push (rd = 7, 0xA5A5A5A5) into an empty FIFO with no ALU traffic → `lsu_count` = 1, then `wenable` = 1, `rd` = 7 exactly two cycles after accept.
- Starvation: ALU valid every cycle (rd = 1..), one LSU entry (rd = 9) pushed → with STARVE_LIMIT = 3, three ALU writes, then `alu_ready` = 0 for one cycle and a write with `rd` = 9.
- FIFO full: LSU valid every cycle with the ALU saturating → `lsu_ready` drops to 0 at `lsu_count` = 2, no entry is lost, and LSU writes emerge in push order (rd 10, 11, 12).
- Reset mid-operation: FIFO holding 2 entries, assert `rst_n` = 0 for 1 cycle → no LSU write ever appears and `lsu_count` = 0.
